// File: rtl/add32.sv
// add32: registered 32-bit two's-complement adder built from a ripple chain of full-adder cells.
// Latency: 1 cycle; operands sampled on rising clk, sum/cout/ovf valid after that edge.
// Backpressure: none; loads every cycle, so one add per cycle with no stall.
//
// Ports:
//   rd    - registered sum rs + rt mod 2^32
//   rs    - operand A (signed two's complement, unregistered)
//   rt    - operand B (signed two's complement, unregistered)
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears rd/cout/ovf
//   cout  - registered unsigned carry out of bit 31
//   ovf   - registered signed overflow flag

// full_adder: one-bit full-adder cell, the repeating element of the carry chain.
// Latency: combinational.
// Backpressure: none.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   // Propagate term is shared between the sum and the carry.
   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

module add32 (
   output logic [31:0] rd,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic        clk,
   input  logic        rst_n,
   output logic        cout,
   output logic        ovf
);

   logic [32:0] c;
   logic [31:0] s;

   assign c[0] = 1'b0;

   // Plain ripple chain: carry of bit i feeds bit i+1. No lookahead and no
   // pipelining, so the bit-0 to bit-31 chain is the critical path.
   for (genvar i = 0; i < 32; i++) begin : g_fa
      full_adder u_fa (
         .a  (rs[i]),
         .b  (rt[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   // Signed overflow is carry into the sign bit differing from carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd   <= 32'd0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         rd   <= s;
         cout <= c[32];
         ovf  <= c[32] ^ c[31];
      end
   end

endmodule

// File: tb/tb_add32.sv
module tb_add32;

   logic [31:0] rd;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        clk;
   logic        rst_n;
   logic        cout;
   logic        ovf;

   int n_checks = 0;
   int n_fail   = 0;

   add32 dut (
      .rd    (rd),
      .rs    (rs),
      .rt    (rt),
      .clk   (clk),
      .rst_n (rst_n),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: wide arithmetic add; overflow from operand/result signs.
   // Returns {cout, ovf, sum}.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] t;
      logic        v;
      t = {1'b0, a} + {1'b0, b};
      v = (a[31] == b[31]) && (t[31] != a[31]);
      return {t[32], v, t[31:0]};
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] specials [6];
      specials[0] = 32'h0000_0000;
      specials[1] = 32'h0000_0001;
      specials[2] = 32'h7FFF_FFFF;
      specials[3] = 32'h8000_0000;
      specials[4] = 32'hFFFF_FFFF;
      specials[5] = 32'h8000_0001;
      if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
      return $urandom();
   endfunction

   task automatic test_reset();
      logic [33:0] exp;
      rst_n = 1'b0;
      rs = 32'h1C71_C71C;
      rt = 32'h1C71_C71C;
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({cout, ovf, rd} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: got cout=%b ovf=%b rd=%h, want all zero", i, cout, ovf, rd);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      exp = model(32'h1C71_C71C, 32'h1C71_C71C);
      n_checks++;
      if ({cout, ovf, rd} !== {2'b00, 32'h38E3_8E38} || {cout, ovf, rd} !== exp) begin
         n_fail++;
         $display("FAIL reset_release: got cout=%b ovf=%b rd=%h, want cout=0 ovf=0 rd=38e38e38", cout, ovf, rd);
      end
   endtask

   task automatic test_directed();
      logic [31:0] va [5] = '{32'h0000_0001, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      logic [31:0] vb [5] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
      logic [33:0] ve [5] = '{{2'b00, 32'h8000_0001}, {2'b00, 32'hFFFF_FFFC}, {2'b10, 32'h0000_0000},
                               {2'b01, 32'h8000_0000}, {2'b11, 32'h0000_0000}};
      for (int i = 0; i < 5; i++) begin
         rs = va[i];
         rt = vb[i];
         @(negedge clk);
         n_checks++;
         if ({cout, ovf, rd} !== ve[i]) begin
            n_fail++;
            $display("FAIL directed%0d rs=%h rt=%h: got cout=%b ovf=%b rd=%h, want %h", i, va[i], vb[i], cout, ovf, rd, ve[i]);
         end
         // Hold an idle vector between cases so each result stands alone.
         rs = 32'd0;
         rt = 32'd0;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [4] = '{32'h0000_0001, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      logic [31:0] vb [4] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
      for (int i = 0; i < 4; i++) begin
         rs = va[i];
         rt = vb[i];
         @(negedge clk);
         n_checks++;
         if ({cout, ovf, rd} !== model(va[i], vb[i])) begin
            n_fail++;
            $display("FAIL stream%0d: got cout=%b ovf=%b rd=%h, want %h", i, cout, ovf, rd, model(va[i], vb[i]));
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      logic [33:0] exp;
      for (int i = 0; i < 300; i++) begin
         a = pick_operand();
         b = pick_operand();
         rs = a;
         rt = b;
         exp = model(a, b);
         @(negedge clk);
         n_checks++;
         if ({cout, ovf, rd} !== exp) begin
            n_fail++;
            $display("FAIL random%0d rs=%h rt=%h: got cout=%b ovf=%b rd=%h, want %h", i, a, b, cout, ovf, rd, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      rs = 32'h8000_0000;
      rt = 32'h8000_0000;
      @(negedge clk);
      n_checks++;
      if ({cout, ovf, rd} !== {2'b11, 32'd0}) begin
         n_fail++;
         $display("FAIL async_pre: got cout=%b ovf=%b rd=%h, want cout=1 ovf=1 rd=0", cout, ovf, rd);
      end
      rs = 32'h1234_5678;
      rt = 32'h1111_1111;
      @(negedge clk);
      n_checks++;
      if ({cout, ovf, rd} !== model(32'h1234_5678, 32'h1111_1111)) begin
         n_fail++;
         $display("FAIL async_loaded: got rd=%h, want 23456789", rd);
      end
      // Drop reset mid low phase: outputs must clear before the next edge.
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cout, ovf, rd} !== 34'd0) begin
         n_fail++;
         $display("FAIL async_clear: got cout=%b ovf=%b rd=%h, want all zero", cout, ovf, rd);
      end
      @(negedge clk);
      n_checks++;
      if ({cout, ovf, rd} !== 34'd0) begin
         n_fail++;
         $display("FAIL async_hold: got cout=%b ovf=%b rd=%h, want all zero", cout, ovf, rd);
      end
      rst_n = 1'b1;
      rs = 32'hFFFF_FFFF;
      rt = 32'hFFFF_FFFF;
      @(negedge clk);
      n_checks++;
      if ({cout, ovf, rd} !== {2'b10, 32'hFFFF_FFFE}) begin
         n_fail++;
         $display("FAIL async_recover: got cout=%b ovf=%b rd=%h, want cout=1 ovf=0 rd=fffffffe", cout, ovf, rd);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
